// File: rtl/sysid_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sysid_checker_pkg
// Description : Shared types and constants for the system-ID checker.
// Revision    : 1.0 - initial release
// ============================================================================
package sysid_checker_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        WT_ID = 3'd2,
        RD_TS = 3'd3,
        WT_TS = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Word addresses inside the sysid slave
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sysid_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : sysid_checker_if
// Description : Avalon-MM read-only bus between the checker and the sysid
//               slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface
`default_nettype wire

// File: rtl/sysid_stall_timer.sv
`default_nettype none
// ============================================================================
// Module      : sysid_stall_timer
// Description : Counts consecutive waitrequest stall cycles of one read and
//               flags expiry on the stall cycle that reaches TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_stall_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam int             c_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT_CYCLES - 1);

    logic [c_W-1:0] r_count;

    // Expiry fires on the stall that would bring the count to TIMEOUT_CYCLES
    assign o_expired = i_inc && (r_count == c_LAST);

    // Stall counter: cleared on request or expiry, otherwise counts stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || o_expired) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + c_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
// Module      : sysid_checker
// Description : Reads the sysid ID and timestamp words over Avalon-MM,
//               compares them with the expected build values and reports
//               pass/fail, retrying the whole sequence on bus timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = 32'd611894095,
    parameter logic [31:0] EXP_TS         = 32'd1557996746,
    parameter int          CHECK_TS       = 1,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRY      = 2,
    parameter int          AUTO_START     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    sysid_checker_if.master        avm,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   id_match,
    output logic                   ts_match,
    output logic                   timeout_err,
    output logic [31:0]            id_value,
    output logic [31:0]            ts_value
);

    localparam logic [1:0] c_LAT_LAST  = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
    localparam logic [2:0] c_MAX_RETRY = 3'(MAX_RETRY);
    localparam logic       c_AUTO      = (AUTO_START != 0);

    state_t      r_state;
    logic        r_read;
    logic        r_addr;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_id_match;
    logic        r_ts_match;
    logic        r_timeout_err;
    logic        r_auto_pend;
    logic [2:0]  r_retry;
    logic [1:0]  r_lat;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic w_in_rd;
    logic w_accept;
    logic w_stall;
    logic w_expired;

    assign w_in_rd  = (r_state == RD_ID) || (r_state == RD_TS);
    assign w_accept = w_in_rd && r_read && !avm.avm_waitrequest;
    assign w_stall  = w_in_rd && r_read &&  avm.avm_waitrequest;

    // Per-read stall limit; restarts whenever a read is accepted or not reading
    sysid_stall_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (!w_in_rd || w_accept),
        .i_inc     (w_stall),
        .o_expired (w_expired)
    );

    // Read sequencer with registered bus strobes and result flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_read        <= 1'b0;
            r_addr        <= ADDR_ID;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_id_match    <= 1'b0;
            r_ts_match    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_auto_pend   <= c_AUTO;
            r_retry       <= 3'd0;
            r_lat         <= 2'd0;
            r_id_value    <= 32'd0;
            r_ts_value    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start || r_auto_pend) begin
                        r_auto_pend   <= 1'b0;
                        r_retry       <= 3'd0;
                        r_pass        <= 1'b0;
                        r_id_match    <= 1'b0;
                        r_ts_match    <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b1;
                        r_read        <= 1'b1;
                        r_addr        <= ADDR_ID;
                        r_state       <= RD_ID;
                    end
                end
                RD_ID, RD_TS: begin
                    if (!r_read) begin
                        // Retry gap: read was dropped for one cycle, re-issue now
                        r_read <= 1'b1;
                    end else if (w_accept) begin
                        r_read <= 1'b0;
                        r_lat  <= 2'd0;
                        if (READ_LATENCY == 0) begin
                            if (r_state == RD_ID) begin
                                r_id_value <= avm.avm_readdata;
                                r_read     <= 1'b1;
                                r_addr     <= ADDR_TS;
                                r_state    <= RD_TS;
                            end else begin
                                r_ts_value <= avm.avm_readdata;
                                r_state    <= CHECK;
                            end
                        end else begin
                            r_state <= (r_state == RD_ID) ? WT_ID : WT_TS;
                        end
                    end else if (w_expired) begin
                        r_read <= 1'b0;
                        if (r_retry < c_MAX_RETRY) begin
                            r_retry <= r_retry + 3'd1;
                            r_addr  <= ADDR_ID;
                            r_state <= RD_ID;
                        end else begin
                            r_timeout_err <= 1'b1;
                            r_pass        <= 1'b0;
                            r_done        <= 1'b1;
                            r_state       <= DONE;
                        end
                    end
                end
                WT_ID, WT_TS: begin
                    if (r_lat == c_LAT_LAST) begin
                        if (r_state == WT_ID) begin
                            r_id_value <= avm.avm_readdata;
                            r_read     <= 1'b1;
                            r_addr     <= ADDR_TS;
                            r_state    <= RD_TS;
                        end else begin
                            r_ts_value <= avm.avm_readdata;
                            r_state    <= CHECK;
                        end
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                CHECK: begin
                    r_id_match <= (r_id_value == EXP_ID);
                    r_ts_match <= (r_ts_value == EXP_TS);
                    r_pass     <= (r_id_value == EXP_ID) &&
                                  ((r_ts_value == EXP_TS) || (CHECK_TS == 0));
                    r_done     <= 1'b1;
                    r_state    <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_read  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign avm.avm_read    = r_read;
    assign avm.avm_address = r_addr;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign id_match        = r_id_match;
    assign ts_match        = r_ts_match;
    assign timeout_err     = r_timeout_err;
    assign id_value        = r_id_value;
    assign ts_value        = r_ts_value;

endmodule
`default_nettype wire
